process_scheduler: RTL and testbench

Parametrised successor to the single-register process keeper. Tracks up to NUM_PROC processes in hardware and owns the context switch: a ready bitmap, a saved-PC table and a round-robin picker, with optional preemption by an instruction-count quantum. Sits beside the PC and the control unit in the core. The control unit's `proc_swap`/exit decode drives it, and it drives the PC load path and the kernel/user `MODE` seen by instruction memory. Process 0 is the OS (kernel mode); processes 1..NUM_PROC-1 are user processes.

---
 rtl/process_scheduler_if.sv | 42 ++++
 rtl/process_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_process_scheduler.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/process_scheduler_if.sv
// Bundle between the core (control unit + PC path) and process_scheduler.
// The core drives the trigger/create side; the scheduler drives PC load, mode and status.
interface process_scheduler_if #(
    parameter int NUM_PROC = 4,
    parameter int PC_WIDTH = 10
);
    localparam int PW = $clog2(NUM_PROC);

    // Triggers are plain levels sampled each cycle: exit/swap/step only count while busy is low,
    // proc_create counts in any cycle; nothing is queued or acknowledged.
    logic                step;
    logic [PC_WIDTH-1:0] cur_pc;
    logic                proc_swap;
    logic [31:0]         new_proc_num;
    logic                proc_exit;
    logic                proc_create;
    logic [31:0]         create_num;
    logic [PC_WIDTH-1:0] create_pc;

    logic [PW-1:0]       exec_proc;
    logic                kernel_mode;
    logic                busy;
    logic                pc_load;
    logic [PC_WIDTH-1:0] pc_value;
    logic [NUM_PROC-1:0] ready_mask;
    logic                bad_proc;
    logic [1:0]          state;

    modport master (
        output step, cur_pc, proc_swap, new_proc_num, proc_exit,
               proc_create, create_num, create_pc,
        input  exec_proc, kernel_mode, busy, pc_load, pc_value,
               ready_mask, bad_proc, state
    );

    modport slave (
        input  step, cur_pc, proc_swap, new_proc_num, proc_exit,
               proc_create, create_num, create_pc,
        output exec_proc, kernel_mode, busy, pc_load, pc_value,
               ready_mask, bad_proc, state
    );
endinterface

// File: rtl/process_scheduler.sv
// Hardware process table with round-robin context switch (RUN->SAVE->PICK->LOAD).
// Define SCHED_PREEMPT_EN to add the instruction-count quantum preemption.
module process_scheduler #(
    parameter int NUM_PROC = 4,
    parameter int PC_WIDTH = 10,
    parameter int QUANTUM  = 64
) (
    input logic                clk,
    input logic                reset,
    process_scheduler_if.slave bus
);
    localparam int PW = $clog2(NUM_PROC);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_SAVE = 2'd1;
    localparam logic [1:0] ST_PICK = 2'd2;
    localparam logic [1:0] ST_LOAD = 2'd3;

    localparam logic [1:0] K_EXIT  = 2'd0;
    localparam logic [1:0] K_SWAP  = 2'd1;
    localparam logic [1:0] K_QUANT = 2'd2;

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);
    localparam logic [31:0]         NP32   = 32'(NUM_PROC);

    logic [1:0]          state_q, state_d;
    logic [1:0]          kind_q, kind_d;
    logic [PW-1:0]       exec_q, exec_d;
    logic [PW-1:0]       target_q, target_d;
    logic [PW-1:0]       pick_q, pick_d;
    logic                kernel_q, kernel_d;
    logic                pc_load_q, pc_load_d;
    logic                bad_q, bad_d;
    logic [PC_WIDTH-1:0] pc_value_q, pc_value_d;
    logic [NUM_PROC-1:0] ready_q, ready_d;
    logic [PC_WIDTH-1:0] table_q [NUM_PROC];
    logic [PC_WIDTH-1:0] table_d [NUM_PROC];

    logic          new_ok, create_ok, quantum_hit, rr_found;
    logic [PW-1:0] new_idx, create_idx, rr_pick;
    int            rr_slot;

    // Any set bit above PW-1 (or an index past NUM_PROC) makes the request invalid.
    assign new_ok     = (bus.new_proc_num < NP32);
    assign create_ok  = (bus.create_num < NP32);
    assign new_idx    = bus.new_proc_num[PW-1:0];
    assign create_idx = bus.create_num[PW-1:0];

`ifdef SCHED_PREEMPT_EN
    localparam logic [15:0] Q_LAST = 16'(QUANTUM - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        cnt_step;

    assign cnt_step    = (state_q == ST_RUN) && bus.step && (exec_q != '0);
    assign quantum_hit = cnt_step && (cnt_q == Q_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_LOAD) begin
            cnt_d = '0;
        end else if (cnt_step) begin
            cnt_d = (cnt_q == Q_LAST) ? 16'd0 : cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_step;

    assign unused_step = bus.step;
    assign quantum_hit = 1'b0;
`endif

    // Scan user slots upward from exec+1, wrapping within 1..NUM_PROC-1; the
    // current process comes up last, and slot 0 is the fallback.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_slot  = 0;
        for (int off = 1; off < NUM_PROC; off++) begin
            rr_slot = (exec_q == '0) ? off - 1 : int'(exec_q) - 1 + off;
            if (rr_slot >= NUM_PROC - 1) begin
                rr_slot = rr_slot - (NUM_PROC - 1);
            end
            rr_slot = rr_slot + 1;
            if (!rr_found && ready_q[rr_slot[PW-1:0]]) begin
                rr_found = 1'b1;
                rr_pick  = rr_slot[PW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        exec_d     = exec_q;
        target_d   = target_q;
        pick_d     = pick_q;
        kernel_d   = kernel_q;
        pc_load_d  = 1'b0;
        bad_d      = bad_q;
        pc_value_d = pc_value_q;
        ready_d    = ready_q;
        table_d    = table_q;

        case (state_q)
            ST_RUN: begin
                if (bus.proc_exit) begin
                    if (exec_q != '0) begin
                        state_d = ST_SAVE;
                        kind_d  = K_EXIT;
                    end else begin
                        bad_d = 1'b1;
                    end
                end else if (bus.proc_swap) begin
                    if (!new_ok || !ready_q[new_idx]) begin
                        bad_d = 1'b1;
                    end else if (new_idx != exec_q) begin
                        state_d  = ST_SAVE;
                        kind_d   = K_SWAP;
                        target_d = new_idx;
                    end
                end else if (quantum_hit) begin
                    state_d = ST_SAVE;
                    kind_d  = K_QUANT;
                end
            end
            ST_SAVE: begin
                if (kind_q == K_EXIT) begin
                    ready_d[exec_q] = 1'b0;
                end else if (kind_q == K_SWAP) begin
                    table_d[exec_q] = bus.cur_pc;
                end else begin
                    // Preempted on the retiring step, so resume after it.
                    table_d[exec_q] = bus.cur_pc + PC_ONE;
                end
                state_d = ST_PICK;
            end
            ST_PICK: begin
                pick_d  = (kind_q == K_SWAP) ? target_q : rr_pick;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                exec_d     = pick_q;
                kernel_d   = (pick_q == '0);
                pc_value_d = table_q[pick_q];
                pc_load_d  = 1'b1;
                state_d    = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase

        // Never collides with the SAVE write: the running slot cannot be created.
        if (bus.proc_create) begin
            if (!create_ok || (create_idx == '0) || (create_idx == exec_q)) begin
                bad_d = 1'b1;
            end else begin
                table_d[create_idx] = bus.create_pc;
                ready_d[create_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            kind_q     <= K_EXIT;
            exec_q     <= '0;
            target_q   <= '0;
            pick_q     <= '0;
            kernel_q   <= 1'b1;
            pc_load_q  <= 1'b0;
            bad_q      <= 1'b0;
            pc_value_q <= '0;
            ready_q    <= NUM_PROC'(1);
            for (int i = 0; i < NUM_PROC; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            exec_q     <= exec_d;
            target_q   <= target_d;
            pick_q     <= pick_d;
            kernel_q   <= kernel_d;
            pc_load_q  <= pc_load_d;
            bad_q      <= bad_d;
            pc_value_q <= pc_value_d;
            ready_q    <= ready_d;
            for (int i = 0; i < NUM_PROC; i++) begin
                table_q[i] <= table_d[i];
            end
        end
    end

    assign bus.exec_proc   = exec_q;
    assign bus.kernel_mode = kernel_q;
    assign bus.busy        = (state_q != ST_RUN);
    assign bus.pc_load     = pc_load_q;
    assign bus.pc_value    = pc_value_q;
    assign bus.ready_mask  = ready_q;
    assign bus.bad_proc    = bad_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_process_scheduler.sv
// Directed bench for process_scheduler (NUM_PROC=4, PC_WIDTH=10, QUANTUM=4).
// Quantum steps are exercised only when SCHED_PREEMPT_EN is defined.
module tb_process_scheduler;
    logic clk;
    logic reset;
    int   total;
    int   bad_n;
    logic [9:0] exp_pc2;

    process_scheduler_if #(.NUM_PROC(4), .PC_WIDTH(10)) bus ();

    process_scheduler #(.NUM_PROC(4), .PC_WIDTH(10), .QUANTUM(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad_n++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic create(input logic [31:0] n, input logic [9:0] pc);
        bus.proc_create = 1'b1;
        bus.create_num  = n;
        bus.create_pc   = pc;
        tick();
        bus.proc_create = 1'b0;
    endtask

    task automatic trig_swap(input logic [31:0] n);
        bus.proc_swap    = 1'b1;
        bus.new_proc_num = n;
        tick();
        bus.proc_swap = 1'b0;
    endtask

    task automatic trig_exit();
        bus.proc_exit = 1'b1;
        tick();
        bus.proc_exit = 1'b0;
    endtask

    // Called one tick after the trigger edge: SAVE, PICK, LOAD, then the pc_load cycle.
    task automatic expect_switch(input string tag, input logic [31:0] exec, input logic [31:0] pc);
        chk({tag, "_busy_save"}, bus.busy, 1);
        tick();
        chk({tag, "_busy_pick"}, bus.busy, 1);
        tick();
        chk({tag, "_busy_load"}, bus.busy, 1);
        tick();
        chk({tag, "_pc_load"}, bus.pc_load, 1);
        chk({tag, "_pc_value"}, bus.pc_value, pc);
        chk({tag, "_exec"}, bus.exec_proc, exec);
        chk({tag, "_kernel"}, bus.kernel_mode, (exec == 0) ? 1 : 0);
        chk({tag, "_busy_done"}, bus.busy, 0);
        tick();
        chk({tag, "_pc_load_drop"}, bus.pc_load, 0);
    endtask

    initial begin
        total            = 0;
        bad_n            = 0;
        reset            = 1'b0;
        bus.step         = 1'b0;
        bus.cur_pc       = '0;
        bus.proc_swap    = 1'b0;
        bus.new_proc_num = '0;
        bus.proc_exit    = 1'b0;
        bus.proc_create  = 1'b0;
        bus.create_num   = '0;
        bus.create_pc    = '0;

        do_reset();
        chk("rst_exec", bus.exec_proc, 0);
        chk("rst_kernel", bus.kernel_mode, 1);
        chk("rst_ready", bus.ready_mask, 32'h1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_bad", bus.bad_proc, 0);
        chk("rst_pc_load", bus.pc_load, 0);
        chk("rst_pc_value", bus.pc_value, 0);

        bus.cur_pc = 10'h010;
        create(1, 10'h040);
        chk("create1_ready", bus.ready_mask, 32'h3);
        create(2, 10'h080);
        chk("create2_ready", bus.ready_mask, 32'h7);

        trig_swap(1);
        expect_switch("swap1", 1, 32'h040);
        chk("swap1_ready", bus.ready_mask, 32'h7);

`ifdef SCHED_PREEMPT_EN
        for (int i = 0; i < 4; i++) begin
            bus.cur_pc = 10'h040 + 10'(i);
            bus.step   = 1'b1;
            tick();
        end
        bus.step = 1'b0;
        expect_switch("quantum1", 2, 32'h080);
        for (int i = 0; i < 4; i++) begin
            bus.cur_pc = 10'h080 + 10'(i);
            bus.step   = 1'b1;
            tick();
        end
        bus.step = 1'b0;
        expect_switch("quantum2", 1, 32'h044);
        exp_pc2 = 10'h084;
`else
        for (int i = 0; i < 6; i++) begin
            bus.step = 1'b1;
            tick();
        end
        bus.step = 1'b0;
        chk("coop_busy", bus.busy, 0);
        chk("coop_exec", bus.exec_proc, 1);
        chk("coop_pc_load", bus.pc_load, 0);
        exp_pc2 = 10'h080;
`endif

        bus.proc_exit    = 1'b1;
        bus.proc_swap    = 1'b1;
        bus.new_proc_num = 32'd2;
        tick();
        bus.proc_exit = 1'b0;
        bus.proc_swap = 1'b0;
        expect_switch("exitswap", 2, 32'(exp_pc2));
        chk("exitswap_ready", bus.ready_mask, 32'h5);

        trig_exit();
        expect_switch("exit2", 0, 32'h010);
        chk("exit2_ready", bus.ready_mask, 32'h1);
        chk("exit2_bad", bus.bad_proc, 0);

        trig_swap(3);
        chk("swap_notready_busy", bus.busy, 0);
        chk("swap_notready_bad", bus.bad_proc, 1);
        tick();
        chk("swap_notready_pc_load", bus.pc_load, 0);
        tick();
        tick();
        chk("bad_sticky", bus.bad_proc, 1);
        chk("swap_notready_exec", bus.exec_proc, 0);

        create(3, 10'h0C0);
        create(1, 10'h100);
        chk("recreate_ready", bus.ready_mask, 32'hB);
        bus.cur_pc = 10'h020;
        trig_swap(3);
        expect_switch("swap3", 3, 32'h0C0);

        trig_swap(3);
        chk("self_swap_busy", bus.busy, 0);
        tick();
        chk("self_swap_pc_load", bus.pc_load, 0);
        chk("self_swap_exec", bus.exec_proc, 3);

        trig_exit();
        expect_switch("wrap", 1, 32'h100);
        chk("wrap_ready", bus.ready_mask, 32'h3);
        chk("wrap_bad", bus.bad_proc, 1);

        trig_swap(0);
        tick();
        reset = 1'b0;
        tick();
        chk("midrst_exec", bus.exec_proc, 0);
        chk("midrst_kernel", bus.kernel_mode, 1);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_pc_load", bus.pc_load, 0);
        chk("midrst_ready", bus.ready_mask, 32'h1);
        chk("midrst_bad", bus.bad_proc, 0);
        chk("midrst_pc_value", bus.pc_value, 0);
        reset = 1'b1;
        tick();
        chk("midrst_stays_idle", bus.busy, 0);

        bus.cur_pc = 10'h030;
        create(1, 10'h200);
        trig_swap(1);
        expect_switch("swapA", 1, 32'h200);
        trig_exit();
        tick();
        bus.proc_create = 1'b1;
        bus.create_num  = 32'd2;
        bus.create_pc   = 10'h300;
        tick();
        bus.proc_create = 1'b0;
        tick();
        chk("precreate_pc_load", bus.pc_load, 1);
        chk("precreate_exec", bus.exec_proc, 0);
        chk("precreate_pc_value", bus.pc_value, 32'h030);
        chk("precreate_ready", bus.ready_mask, 32'h5);

        do_reset();
        create(0, 10'h111);
        chk("create0_bad", bus.bad_proc, 1);
        chk("create0_ready", bus.ready_mask, 32'h1);

        do_reset();
        create(32'h11, 10'h111);
        chk("create_range_bad", bus.bad_proc, 1);
        chk("create_range_ready", bus.ready_mask, 32'h1);

        do_reset();
        chk("rst2_bad", bus.bad_proc, 0);
        trig_swap(32'h10);
        chk("swap_range_busy", bus.busy, 0);
        chk("swap_range_bad", bus.bad_proc, 1);

        do_reset();
        trig_exit();
        chk("exit_kernel_busy", bus.busy, 0);
        chk("exit_kernel_bad", bus.bad_proc, 1);

        $display("test done: total=%0d bad=%0d", total, bad_n);
        $finish;
    end
endmodule
